fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch path. It owns the program counter and issues one instruction-memory read at a time through a valid/ready request port. Returned words go into a small instruction queue that feeds decode. It also handles branch/jump redirects by flushing the queue and discarding any stale in-flight response. It sits between the PC-override logic from execute and the instruction memory/L1i port.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] ignored (forced 0).
QDEPTH, 2, instruction-queue entries; power of two, 2..8.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
redirect_valid  input  1  branch/jump PC override this cycle
redirect_pc  input  32  target PC; bits [1:0] forced 0 internally
mem_req_valid  output  1  fetch request to instruction memory
mem_req_ready  input  1  memory accepts request this cycle
mem_req_addr  output  32  word-aligned fetch address
mem_resp_valid  input  1  read data returned (latency >= 1 cycle after acceptance)
mem_resp_data  input  32  returned instruction word
inst_valid  output  1  queue head valid to decode
inst_ready  input  1  decode consumes head this cycle
inst_data  output  32  head instruction word
inst_pc  output  32  PC of head instruction
busy  output  1  request outstanding (WAIT or DRAIN)

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, queue empty, state ISSUE. Outputs the cycle after reset: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, busy=0. rst overrides every other input, including mid-transaction; a response arriving after reset with no request outstanding is ignored.
- States:
  - ISSUE: mem_req_valid=1 iff queue count < QDEPTH (space is reserved for the single outstanding request). mem_req_addr=pc, combinational from the pc register. On mem_req_valid&&mem_req_ready: req_pc<=pc, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - WAIT: mem_req_valid=0. On mem_resp_valid, push {mem_resp_data, req_pc} into the queue, then go to ISSUE. A request may issue in the cycle after the response (minimum 2 cycles per fetch).
  - DRAIN: one stale request is outstanding. On mem_resp_valid, discard the data and go to ISSUE.
- Redirect (redirect_valid=1) takes priority over everything except rst:
  - pc<=redirect_pc and the queue is flushed. inst_valid=0 next cycle; a same-cycle inst_ready pop is irrelevant.
  - ISSUE with request accepted the same cycle: go to DRAIN.
  - ISSUE with no acceptance: stay in ISSUE and issue from the new pc next cycle.
  - WAIT with no response: go to DRAIN.
  - WAIT with a same-cycle response: discard the response, go to ISSUE.
  - DRAIN: pc updated; DRAIN is held unless a response arrives the same cycle (then go to ISSUE).
- Request stability: once mem_req_valid is asserted, mem_req_addr and mem_req_valid hold until acceptance, unless a redirect occurs.
- Queue:
  - FIFO; simultaneous push and pop allowed, count unchanged.
  - Pop requires inst_valid&&inst_ready.
  - A push when full cannot occur by construction. The bench asserts this.
  - inst_data and inst_pc come from registered storage; both read 0 when empty.
- Spurious response (mem_resp_valid in ISSUE): ignored, no state change.
- busy = (state==WAIT || state==DRAIN).

Optional Feature:
FETCH_PERF_CNT_EN defined adds three output ports, all reset to 0 and saturating, not wrapping:
- perf_fetch_cnt[31:0]: +1 per word pushed into the queue.
- perf_stall_cnt[31:0]: +1 per cycle where state==ISSUE and the queue is full.
- perf_flush_cnt[15:0]: +1 per cycle with redirect_valid=1 while not in reset.
Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h100, memory always ready, 1-cycle response, inst_ready=1 -> inst_pc sequence 0x100, 0x104, 0x108, one instruction every 2 cycles; inst_data matches memory.
- inst_ready=0 with QDEPTH=2 -> exactly 2 words queued, then mem_req_valid stays 0. Raise inst_ready -> fetching resumes at 0x108 with no gaps or duplicates in the pc sequence.
- redirect_pc=32'h200 in WAIT, stale response 3 cycles later with data 0xDEAD -> 0xDEAD never appears on inst_data; next mem_req_addr=0x200.
- redirect_pc=32'h203 in the same cycle as request acceptance -> DRAIN entered, next issued address 0x200, queue flushed (inst_valid=0 the next cycle).
- pc at 32'hFFFF_FFFC -> following request address is 0x0. rst asserted while in WAIT -> outputs at reset values next cycle, late response ignored.
- With FETCH_PERF_CNT_EN: 5 fetches, 3 full-queue cycles, 1 redirect -> perf_fetch_cnt=5, perf_stall_cnt=3, perf_flush_cnt=1.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-path bus bundle: instruction-memory request/response and the
// instruction-queue head presented to decode.
// master = fetch sequencer side, slave = memory/decode environment side.
interface fetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one instruction-memory
// read at a time, queues returned words for decode and handles redirects
// by flushing the queue and dropping the stale in-flight response.
// Optional macro FETCH_PERF_CNT_EN adds saturating performance counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     bus,
  output logic        busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam logic [1:0] ST_ISSUE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0]  QFULL   = CW'(QDEPTH);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [QAW-1:0] PTR_ONE = QAW'(1);
  localparam logic [31:0]    ALIGN   = 32'hFFFF_FFFC;

  logic [1:0]     state;
  logic [31:0]    pc;
  logic [31:0]    req_pc;
  logic           boot;
  logic [CW-1:0]  count;
  logic [QAW-1:0] wr_ptr;
  logic [QAW-1:0] rd_ptr;
  logic [31:0]    q_data [QDEPTH];
  logic [31:0]    q_pc   [QDEPTH];

  logic full;
  logic accept;
  logic push;
  logic pop;

  // Request/queue handshakes; the request is held off for one cycle after
  // reset so the memory port comes up idle.
  always_comb begin
    full              = (count == QFULL);
    bus.mem_req_valid = (state == ST_ISSUE) && !boot && !full;
    bus.mem_req_addr  = pc;
    accept            = bus.mem_req_valid && bus.mem_req_ready;
    push              = (state == ST_WAIT) && bus.mem_resp_valid && !redirect_valid;
    bus.inst_valid    = (count != '0);
    pop               = bus.inst_valid && bus.inst_ready && !redirect_valid;
    bus.inst_data     = bus.inst_valid ? q_data[rd_ptr] : '0;
    bus.inst_pc       = bus.inst_valid ? q_pc[rd_ptr]   : '0;
    busy              = (state == ST_WAIT) || (state == ST_DRAIN);
  end

  // Sequencer state, PC and queue pointers; a redirect flushes the queue and
  // turns an outstanding request into one to be drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_ISSUE;
      pc     <= RESET_PC & ALIGN;
      boot   <= 1'b1;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      boot <= 1'b0;
      if (redirect_valid) begin
        pc     <= redirect_pc & ALIGN;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        case (state)
          ST_ISSUE: if (accept) state <= ST_DRAIN;
          ST_WAIT:  state <= bus.mem_resp_valid ? ST_ISSUE : ST_DRAIN;
          ST_DRAIN: if (bus.mem_resp_valid) state <= ST_ISSUE;
          default:  state <= ST_ISSUE;
        endcase
      end else begin
        case (state)
          ST_ISSUE: if (accept) begin
            pc    <= pc + 32'd4;
            state <= ST_WAIT;
          end
          ST_WAIT:  if (bus.mem_resp_valid) state <= ST_ISSUE;
          ST_DRAIN: if (bus.mem_resp_valid) state <= ST_ISSUE;
          default:  state <= ST_ISSUE;
        endcase
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (!push && pop) count <= count - CNT_ONE;
      end
    end
  end

  // Request PC and queue storage are pure data and carry no reset.
  always_ff @(posedge clk) begin
    if (accept) req_pc <= pc;
    if (push) begin
      q_data[wr_ptr] <= bus.mem_resp_data;
      q_pc[wr_ptr]   <= req_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters: words fetched, full-queue stalls, redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == ST_ISSUE) && full && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
